// File: rtl/bus_arb_pkg.sv
// bus_arb shared definitions: source ids, FSM states, size-to-beats helper.
// Used by bus_arb and bus_arb_rdtrack.
package bus_arb_pkg;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Sizes of 8 bytes and up span (sz+1)/8 64-bit beats.
  function automatic logic [2:0] sz2beats(input logic [4:0] sz);
    logic [5:0] w_n;
    w_n = {1'b0, sz} + 6'd1;
    return (sz >= 5'd8) ? w_n[5:3] : 3'd1;
  endfunction

endpackage

// File: rtl/bus_arb_rdtrack.sv
// Per-source outstanding-read tracker: read count, beat counter and a
// small FIFO of expected beat counts, one entry per outstanding read.
module bus_arb_rdtrack
  import bus_arb_pkg::*;
#(
  parameter int MAX_RD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [4:0] i_sz,
  input  logic       i_beat,
  input  logic       i_err,
  output logic [1:0] o_cnt,
  output logic       o_uflow
);

  logic [1:0] r_cnt;
  logic [2:0] r_bcnt;
  logic [2:0] r_q  [MAX_RD];
  logic [2:0] w_qn [MAX_RD];
  logic       w_busy;
  logic       w_last;
  logic       w_pop;
  logic [1:0] w_widx;

  assign w_busy  = (r_cnt != 2'd0);
  assign w_last  = i_err || ((r_bcnt + 3'd1) == r_q[0]);
  assign w_pop   = i_beat && w_busy && w_last;
  assign w_widx  = w_pop ? (r_cnt - 2'd1) : r_cnt;
  assign o_cnt   = r_cnt;
  assign o_uflow = i_beat && !w_busy;

  // Head entry is the read whose beats are arriving now.
  always_comb begin
    w_qn = r_q;
    if (w_pop) begin
      for (int k = 0; k < MAX_RD - 1; k++) begin
        w_qn[k] = r_q[k+1];
      end
      w_qn[MAX_RD-1] = 3'd0;
    end
    if (i_push) begin
      for (int k = 0; k < MAX_RD; k++) begin
        if (2'(k) == w_widx) begin
          w_qn[k] = sz2beats(i_sz);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_bcnt <= 3'd0;
      for (int k = 0; k < MAX_RD; k++) begin
        r_q[k] <= 3'd0;
      end
    end else begin
      r_q <= w_qn;
      unique case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: ;
      endcase
      if (w_pop) begin
        r_bcnt <= 3'd0;
      end else if (i_beat && w_busy) begin
        r_bcnt <= r_bcnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/bus_arb.sv
// SysAD request-port arbiter between icache (src 0) and dcache (src 1).
// Define BUS_ARB_STATS_EN to add grant/wait/error statistics outputs.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int MAX_RD     = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef BUS_ARB_STATS_EN
  output logic [15:0] stat_igrant,
  output logic [15:0] stat_dgrant,
  output logic [15:0] stat_wait,
  output logic        stat_err,
`endif
  input  logic        phi2,
  input  logic        ireq,
  input  logic        dreq,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [63:0] iwdata,
  input  logic [63:0] dwdata,
  input  logic [4:0]  isz,
  input  logic [4:0]  dsz,
  input  logic        iwr,
  input  logic        dwr,
  output logic        iack,
  output logic        dack,
  output logic        irvalid,
  output logic        drvalid,
  output logic        irerr,
  output logic        drerr,
  output logic [63:0] rdata,
  output logic [31:0] extaddr,
  output logic [63:0] extwdata,
  output logic [4:0]  extsz,
  output logic        extwr,
  output logic        extsrc,
  output logic        extreq,
  input  logic        extrdy,
  input  logic        extreply,
  input  logic        extreplyto,
  input  logic [63:0] extrdata,
  input  logic        exterror
);

  localparam int             SW  = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STV = SW'(STARVE_MAX);
  localparam logic [1:0]     RDM = 2'(MAX_RD);

  state_t      r_state;
  state_t      w_nstate;
  logic        w_load;
  logic [31:0] r_addr;
  logic [63:0] r_wdata;
  logic [4:0]  r_sz;
  logic        r_wr;
  logic        r_src;
  logic [SW-1:0] r_starve;

  logic [1:0]  w_icnt;
  logic [1:0]  w_dcnt;
  logic        w_iuf;
  logic        w_duf;
  logic        w_ielig;
  logic        w_delig;
  logic        w_isel;
  logic        w_accept;
  logic        w_ibeat;
  logic        w_dbeat;

  assign w_ielig  = ireq && (iwr || (w_icnt < RDM));
  assign w_delig  = dreq && (dwr || (w_dcnt < RDM));
  assign w_isel   = w_ielig && (!w_delig || (r_starve == STV));
  assign w_accept = (r_state == OFFER) && phi2 && extrdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_load   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ielig || w_delig) begin
          w_nstate = OFFER;
          w_load   = 1'b1;
        end
      end
      OFFER: begin
        if (w_accept) begin
          w_nstate = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= 32'd0;
      r_wdata <= 64'd0;
      r_sz    <= 5'd0;
      r_wr    <= 1'b0;
      r_src   <= SRC_I;
    end else if (w_load) begin
      if (w_isel) begin
        r_addr  <= iaddr;
        r_wdata <= iwdata;
        r_sz    <= isz;
        r_wr    <= iwr;
        r_src   <= SRC_I;
      end else begin
        r_addr  <= daddr;
        r_wdata <= dwdata;
        r_sz    <= dsz;
        r_wr    <= dwr;
        r_src   <= SRC_D;
      end
    end
  end

  // Only dcache wins that were taken while icache could have gone count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!ireq || iack) begin
      r_starve <= '0;
    end else if (dack && w_ielig && (r_starve != STV)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign extaddr  = r_addr;
  assign extwdata = r_wdata;
  assign extsz    = r_sz;
  assign extwr    = r_wr;
  assign extsrc   = r_src;
  assign extreq   = (r_state == OFFER);
  assign iack     = w_accept && (r_src == SRC_I);
  assign dack     = w_accept && (r_src == SRC_D);

  assign w_ibeat  = extreply && (extreplyto == SRC_I);
  assign w_dbeat  = extreply && (extreplyto == SRC_D);
  assign irvalid  = w_ibeat;
  assign drvalid  = w_dbeat;
  assign irerr    = w_ibeat && exterror;
  assign drerr    = w_dbeat && exterror;
  assign rdata    = extrdata;

  bus_arb_rdtrack #(.MAX_RD(MAX_RD)) u_rd_i (
    .clk     (clk),
    .rst     (rst),
    .i_push  (iack && !r_wr),
    .i_sz    (r_sz),
    .i_beat  (w_ibeat),
    .i_err   (exterror),
    .o_cnt   (w_icnt),
    .o_uflow (w_iuf)
  );

  bus_arb_rdtrack #(.MAX_RD(MAX_RD)) u_rd_d (
    .clk     (clk),
    .rst     (rst),
    .i_push  (dack && !r_wr),
    .i_sz    (r_sz),
    .i_beat  (w_dbeat),
    .i_err   (exterror),
    .o_cnt   (w_dcnt),
    .o_uflow (w_duf)
  );

`ifdef BUS_ARB_STATS_EN
  logic [15:0] r_igrant;
  logic [15:0] r_dgrant;
  logic [15:0] r_wait;
  logic        r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_igrant <= 16'd0;
      r_dgrant <= 16'd0;
      r_wait   <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      if (iack) r_igrant <= r_igrant + 16'd1;
      if (dack) r_dgrant <= r_dgrant + 16'd1;
      if (extreq && !extrdy && (r_wait != 16'hFFFF)) begin
        r_wait <= r_wait + 16'd1;
      end
      r_err <= r_err | w_iuf | w_duf;
    end
  end

  assign stat_igrant = r_igrant;
  assign stat_dgrant = r_dgrant;
  assign stat_wait   = r_wait;
  assign stat_err    = r_err;
`else
  logic w_unused;
  assign w_unused = w_iuf | w_duf;
`endif

endmodule
